// File: rtl/id_stage_p.sv
// Instruction-decode stage: field decode, 16-entry register file with optional
// write-through bypass, load-use hazard detection and the ID/EX pipeline register.
module id_stage_p #(
  parameter int unsigned DATA_W  = 16,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          R0_ZERO = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [15:0]       i_instr,
  input  logic              i_valid,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic [3:0]        i_wrReg,
  input  logic [DATA_W-1:0] i_wrData,
  input  logic              i_wrEn,
  output logic              o_stall,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_port0,
  output logic [DATA_W-1:0] o_port1,
  output logic [DATA_W-1:0] o_sext,
  output logic [15:0]       o_instr,
  output logic [3:0]        o_wrReg,
  output logic [3:0]        o_aluOp,
  output logic [3:0]        o_shAmt,
  output logic [3:0]        o_rdReg1,
  output logic [3:0]        o_rdReg2,
  output logic              o_memRd,
  output logic              o_memWr,
  output logic              o_mem2reg,
  output logic              o_sawBr,
  output logic              o_sawJ,
  output logic              o_aluSrc,
  output logic              o_wrRegEn,
  output logic              o_hlt
);

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_NOR, OP_SLL, OP_SRL, OP_SRA, OP_NOP,
    OP_LW,  OP_SW,  OP_LHB, OP_LLB, OP_B,   OP_JAL, OP_JR,  OP_HLT
  } op_e;

  typedef enum logic {ST_RUN, ST_HALTED} state_e;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] port0;
    logic [DATA_W-1:0] port1;
    logic [DATA_W-1:0] sext;
    logic [15:0]       instr;
    logic [3:0]        wr_reg;
    logic [3:0]        alu_op;
    logic [3:0]        sh_amt;
    logic [3:0]        rd_reg1;
    logic [3:0]        rd_reg2;
    logic              mem_rd;
    logic              mem_wr;
    logic              mem2reg;
    logic              saw_br;
    logic              saw_j;
    logic              alu_src;
    logic              wr_reg_en;
    logic              hlt;
  } idex_t;

  logic [DATA_W-1:0] regs [16];
  idex_t             dec, idex_d, idex_q;
  state_e            state_q, state_d;
  op_e               op;
  logic              en1, en2, haz1, haz2, load;

  assign op = op_e'(i_instr[15:12]);

  function automatic logic [DATA_W-1:0] rf_read(input logic [3:0] a);
    logic [DATA_W-1:0] v;
    if (R0_ZERO && a == 4'd0)
      v = '0;
    else if (BYPASS && i_wrEn && i_wrReg == a)
      v = i_wrData;
    else
      v = regs[a];
    return v;
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < 16; i++) regs[i] <= '0;
    end else if (i_wrEn && !(R0_ZERO && i_wrReg == 4'd0)) begin
      regs[i_wrReg] <= i_wrData;
    end
  end

  always_comb begin
    dec        = '0;
    en1        = 1'b0;
    en2        = 1'b0;
    dec.valid  = 1'b1;
    dec.instr  = i_instr;
    dec.alu_op = i_instr[15:12];
    dec.sh_amt = i_instr[3:0];
    dec.wr_reg = i_instr[11:8];
    dec.sext   = DATA_W'($signed(i_instr[7:0]));
    unique case (op)
      OP_ADD, OP_SUB, OP_AND, OP_NOR: begin
        dec.rd_reg1 = i_instr[7:4];
        dec.rd_reg2 = i_instr[3:0];
        en1 = 1'b1;
        en2 = 1'b1;
        dec.wr_reg_en = 1'b1;
      end
      OP_SLL, OP_SRL, OP_SRA: begin
        dec.rd_reg1 = i_instr[7:4];
        dec.rd_reg2 = i_instr[3:0];
        en1 = 1'b1;
        dec.wr_reg_en = 1'b1;
      end
      OP_NOP: ;
      OP_LW: begin
        dec.rd_reg1   = i_instr[7:4];
        en1           = 1'b1;
        dec.mem_rd    = 1'b1;
        dec.mem2reg   = 1'b1;
        dec.alu_src   = 1'b1;
        dec.wr_reg_en = 1'b1;
        dec.sext      = DATA_W'($signed(i_instr[3:0]));
      end
      OP_SW: begin
        dec.rd_reg1 = i_instr[7:4];
        dec.rd_reg2 = i_instr[11:8];
        en1         = 1'b1;
        en2         = 1'b1;
        dec.mem_wr  = 1'b1;
        dec.alu_src = 1'b1;
        dec.sext    = DATA_W'($signed(i_instr[3:0]));
      end
      OP_LHB, OP_LLB: begin
        dec.rd_reg1   = i_instr[11:8];
        en1           = 1'b1;
        dec.alu_src   = 1'b1;
        dec.wr_reg_en = 1'b1;
      end
      OP_B: begin
        dec.saw_br = 1'b1;
        dec.sext   = DATA_W'($signed(i_instr[8:0]));
      end
      OP_JAL: begin
        dec.saw_j     = 1'b1;
        dec.wr_reg_en = 1'b1;
        dec.wr_reg    = 4'd15;
      end
      OP_JR: begin
        dec.saw_j   = 1'b1;
        dec.rd_reg1 = i_instr[7:4];
        en1         = 1'b1;
      end
      OP_HLT: dec.hlt = 1'b1;
      default: ;
    endcase
    dec.port0 = rf_read(dec.rd_reg1);
    dec.port1 = rf_read(dec.rd_reg2);
  end

  // Only enabled read ports can raise a hazard; r0 never does when it is hardwired.
  assign haz1 = en1 && dec.rd_reg1 == idex_q.wr_reg && (!R0_ZERO || dec.rd_reg1 != 4'd0);
  assign haz2 = en2 && dec.rd_reg2 == idex_q.wr_reg && (!R0_ZERO || dec.rd_reg2 != 4'd0);
  assign o_stall = i_valid && idex_q.valid && idex_q.mem_rd && (haz1 || haz2);

  assign load = i_valid && !o_stall && state_q == ST_RUN;

  always_comb begin
    idex_d  = idex_q;
    state_d = state_q;
    if (i_flush) begin
      idex_d = '0;
    end else if (!i_stall) begin
      if (load) begin
        idex_d = dec;
        if (op == OP_HLT) state_d = ST_HALTED;
      end else begin
        idex_d = '0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idex_q  <= '0;
      state_q <= ST_RUN;
    end else begin
      idex_q  <= idex_d;
      state_q <= state_d;
    end
  end

  assign o_valid   = idex_q.valid;
  assign o_port0   = idex_q.port0;
  assign o_port1   = idex_q.port1;
  assign o_sext    = idex_q.sext;
  assign o_instr   = idex_q.instr;
  assign o_wrReg   = idex_q.wr_reg;
  assign o_aluOp   = idex_q.alu_op;
  assign o_shAmt   = idex_q.sh_amt;
  assign o_rdReg1  = idex_q.rd_reg1;
  assign o_rdReg2  = idex_q.rd_reg2;
  assign o_memRd   = idex_q.mem_rd;
  assign o_memWr   = idex_q.mem_wr;
  assign o_mem2reg = idex_q.mem2reg;
  assign o_sawBr   = idex_q.saw_br;
  assign o_sawJ    = idex_q.saw_j;
  assign o_aluSrc  = idex_q.alu_src;
  assign o_wrRegEn = idex_q.wr_reg_en;
  assign o_hlt     = idex_q.hlt;

endmodule

// File: tb/tb_id_stage_p.sv
// Scoreboard bench for id_stage_p: a bypassing and a non-bypassing instance share
// stimulus; expected ID/EX contents are queued per cycle and popped after the edge.
module tb_id_stage_p;

  logic        clk = 1'b0;
  logic        i_rst, i_valid, i_stall, i_flush, i_wrEn;
  logic [15:0] i_instr, i_wrData;
  logic [3:0]  i_wrReg;

  logic        o_stall, o_valid, o_memRd, o_memWr, o_mem2reg, o_sawBr, o_sawJ, o_aluSrc, o_wrRegEn, o_hlt;
  logic [15:0] o_port0, o_port1, o_sext, o_instr;
  logic [3:0]  o_wrReg, o_aluOp, o_shAmt, o_rdReg1, o_rdReg2;

  logic        n_stall, n_valid, n_memRd, n_memWr, n_mem2reg, n_sawBr, n_sawJ, n_aluSrc, n_wrRegEn, n_hlt;
  logic [15:0] n_port0, n_port1, n_sext, n_instr;
  logic [3:0]  n_wrReg, n_aluOp, n_shAmt, n_rdReg1, n_rdReg2;

  always #5 clk = ~clk;

  id_stage_p #(.DATA_W(16), .BYPASS(1'b1), .R0_ZERO(1'b1)) u_dut (
    .i_clk(clk), .i_rst(i_rst), .i_instr(i_instr), .i_valid(i_valid), .i_stall(i_stall),
    .i_flush(i_flush), .i_wrReg(i_wrReg), .i_wrData(i_wrData), .i_wrEn(i_wrEn),
    .o_stall(o_stall), .o_valid(o_valid), .o_port0(o_port0), .o_port1(o_port1),
    .o_sext(o_sext), .o_instr(o_instr), .o_wrReg(o_wrReg), .o_aluOp(o_aluOp),
    .o_shAmt(o_shAmt), .o_rdReg1(o_rdReg1), .o_rdReg2(o_rdReg2), .o_memRd(o_memRd),
    .o_memWr(o_memWr), .o_mem2reg(o_mem2reg), .o_sawBr(o_sawBr), .o_sawJ(o_sawJ),
    .o_aluSrc(o_aluSrc), .o_wrRegEn(o_wrRegEn), .o_hlt(o_hlt));

  id_stage_p #(.DATA_W(16), .BYPASS(1'b0), .R0_ZERO(1'b1)) u_nb (
    .i_clk(clk), .i_rst(i_rst), .i_instr(i_instr), .i_valid(i_valid), .i_stall(i_stall),
    .i_flush(i_flush), .i_wrReg(i_wrReg), .i_wrData(i_wrData), .i_wrEn(i_wrEn),
    .o_stall(n_stall), .o_valid(n_valid), .o_port0(n_port0), .o_port1(n_port1),
    .o_sext(n_sext), .o_instr(n_instr), .o_wrReg(n_wrReg), .o_aluOp(n_aluOp),
    .o_shAmt(n_shAmt), .o_rdReg1(n_rdReg1), .o_rdReg2(n_rdReg2), .o_memRd(n_memRd),
    .o_memWr(n_memWr), .o_mem2reg(n_mem2reg), .o_sawBr(n_sawBr), .o_sawJ(n_sawJ),
    .o_aluSrc(n_aluSrc), .o_wrRegEn(n_wrRegEn), .o_hlt(n_hlt));

  // ctl = {memRd, memWr, mem2reg, sawBr, sawJ, aluSrc, wrRegEn}
  typedef struct {
    logic [15:0] instr;
    bit          v;
    logic [15:0] p0, p1, p0nb, sx;
    logic [3:0]  wr, r1, r2;
    logic [6:0]  ctl;
    bit          h;
    bit          u1, u2;
  } exp_t;

  exp_t        q[$];
  exp_t        last;
  bit          m_halted;
  logic [15:0] rf [16];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t bubble();
    exp_t e;
    e = '{default: '0};
    return e;
  endfunction

  function automatic logic [15:0] rdv(input logic [3:0] a, input bit byp);
    if (a == 4'd0) return 16'h0;
    if (byp && i_wrEn && i_wrReg == a) return i_wrData;
    return rf[a];
  endfunction

  function automatic exp_t golden(input logic [15:0] ins);
    exp_t e;
    e       = '{default: '0};
    e.instr = ins;
    e.v     = 1'b1;
    e.wr    = ins[11:8];
    e.sx    = {{8{ins[7]}}, ins[7:0]};
    case (ins[15:12])
      4'd0, 4'd1, 4'd2, 4'd3: begin e.r1 = ins[7:4]; e.r2 = ins[3:0]; e.u1 = 1; e.u2 = 1; e.ctl = 7'b0000001; end
      4'd4, 4'd5, 4'd6:       begin e.r1 = ins[7:4]; e.r2 = ins[3:0]; e.u1 = 1; e.ctl = 7'b0000001; end
      4'd8:  begin e.r1 = ins[7:4]; e.u1 = 1; e.ctl = 7'b1010011; e.sx = {{12{ins[3]}}, ins[3:0]}; end
      4'd9:  begin e.r1 = ins[7:4]; e.r2 = ins[11:8]; e.u1 = 1; e.u2 = 1; e.ctl = 7'b0100010;
                   e.sx = {{12{ins[3]}}, ins[3:0]}; end
      4'd10, 4'd11: begin e.r1 = ins[11:8]; e.u1 = 1; e.ctl = 7'b0000011; end
      4'd12: begin e.ctl = 7'b0001000; e.sx = {{7{ins[8]}}, ins[8:0]}; end
      4'd13: begin e.ctl = 7'b0000101; e.wr = 4'd15; end
      4'd14: begin e.r1 = ins[7:4]; e.u1 = 1; e.ctl = 7'b0000100; end
      4'd15: e.h = 1'b1;
      default: ;
    endcase
    e.p0   = rdv(e.r1, 1'b1);
    e.p1   = rdv(e.r2, 1'b1);
    e.p0nb = rdv(e.r1, 1'b0);
    return e;
  endfunction

  task automatic compare(input string tag, input exp_t e);
    check({tag, ".valid"}, o_valid, e.v);
    check({tag, ".port0"}, o_port0, e.p0);
    check({tag, ".port1"}, o_port1, e.p1);
    check({tag, ".port0_nb"}, n_port0, e.p0nb);
    check({tag, ".sext"}, o_sext, e.sx);
    check({tag, ".instr"}, o_instr, e.instr);
    check({tag, ".aluop_sh"}, {o_aluOp, o_shAmt}, {e.instr[15:12], e.instr[3:0]});
    check({tag, ".wrreg"}, o_wrReg, e.wr);
    check({tag, ".rdregs"}, {o_rdReg1, o_rdReg2}, {e.r1, e.r2});
    check({tag, ".ctl"}, {o_memRd, o_memWr, o_mem2reg, o_sawBr, o_sawJ, o_aluSrc, o_wrRegEn}, e.ctl);
    check({tag, ".hlt"}, o_hlt, e.h);
    check({tag, ".nb_valid"}, n_valid, e.v);
  endtask

  task automatic step(input string tag, input logic [15:0] ins, input bit v, input bit st, input bit fl,
                      input bit we, input logic [3:0] wa, input logic [15:0] wd);
    exp_t g, nxt;
    bit   exp_st;
    i_instr = ins; i_valid = v; i_stall = st; i_flush = fl;
    i_wrEn = we; i_wrReg = wa; i_wrData = wd;
    #1;
    g = golden(ins);
    exp_st = v && last.v && last.ctl[6] &&
             ((g.u1 && g.r1 == last.wr && g.r1 != 0) || (g.u2 && g.r2 == last.wr && g.r2 != 0));
    check({tag, ".stall"}, o_stall, exp_st);
    check({tag, ".stall_nb"}, n_stall, exp_st);
    if (fl) nxt = bubble();
    else if (st) nxt = last;
    else if (exp_st || !v || m_halted) nxt = bubble();
    else nxt = g;
    q.push_back(nxt);
    @(posedge clk);
    #1;
    if (!fl && !st && !exp_st && v && !m_halted && ins[15:12] == 4'd15) m_halted = 1'b1;
    if (we && wa != 4'd0) rf[wa] = wd;
    last = q.pop_front();
    compare(tag, last);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) rf[i] = 16'h0;
    m_halted = 1'b0;
    last = bubble();
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 0; i_stall = 0; i_flush = 0; i_wrEn = 0;
    i_instr = 16'h0; i_wrReg = 4'h0; i_wrData = 16'h0;
    model_reset();
    #12;
    compare("reset", bubble());
    check("reset.stall", o_stall, 1'b0);
    i_rst = 1'b0;
    @(posedge clk);
    #1;

    step("rd_zero",  16'h0123, 1, 0, 0, 0, 4'h0, 16'h0);
    step("bypass",   16'h0134, 1, 0, 0, 1, 4'h3, 16'h1234);
    step("after_wr", 16'h0134, 1, 0, 0, 1, 4'h4, 16'h00AA);
    step("idle_wr",  16'h0000, 0, 0, 0, 1, 4'h2, 16'h0100);
    step("lw",       16'h8521, 1, 0, 0, 0, 4'h0, 16'h0);
    step("lu_stall", 16'h0657, 1, 0, 0, 0, 4'h0, 16'h0);
    step("lu_go",    16'h0657, 1, 0, 0, 0, 4'h0, 16'h0);
    step("lw_r0",    16'h8021, 1, 0, 0, 0, 4'h0, 16'h0);
    step("r0_nohaz", 16'h0607, 1, 0, 0, 0, 4'h0, 16'h0);
    step("sw",       16'h942F, 1, 0, 0, 0, 4'h0, 16'h0);
    step("jal",      16'hD000, 1, 0, 0, 0, 4'h0, 16'h0);
    step("br",       16'hC1F0, 1, 0, 0, 0, 4'h0, 16'h0);
    step("lhb",      16'hA780, 1, 0, 0, 0, 4'h0, 16'h0);
    step("sll",      16'h4234, 1, 0, 0, 0, 4'h0, 16'h0);
    step("op7",      16'h7123, 1, 0, 0, 0, 4'h0, 16'h0);
    step("jr",       16'hE300, 1, 0, 0, 0, 4'h0, 16'h0);
    step("pre_hold", 16'h0134, 1, 0, 0, 0, 4'h0, 16'h0);
    for (int i = 0; i < 3; i++) step("hold", 16'h1567 + 16'(i), 1, 1, 0, 0, 4'h0, 16'h0);
    step("flush_st", 16'h0134, 1, 1, 1, 0, 4'h0, 16'h0);
    step("lw2",      16'h8521, 1, 0, 0, 0, 4'h0, 16'h0);
    step("ist_win",  16'h0657, 1, 1, 0, 0, 4'h0, 16'h0);
    step("ost_bub",  16'h0657, 1, 0, 0, 0, 4'h0, 16'h0);
    step("ost_go",   16'h0657, 1, 0, 0, 0, 4'h0, 16'h0);
    step("sw_haz",   16'h8321, 1, 0, 0, 0, 4'h0, 16'h0);
    step("sw_stall", 16'h9340, 1, 0, 0, 0, 4'h0, 16'h0);
    step("hlt_fl",   16'hF000, 1, 0, 1, 0, 4'h0, 16'h0);
    step("no_halt",  16'h0134, 1, 0, 0, 0, 4'h0, 16'h0);
    step("hlt",      16'hF000, 1, 0, 0, 0, 4'h0, 16'h0);
    step("halted1",  16'h0134, 1, 0, 0, 1, 4'h9, 16'h5A5A);
    step("halted2",  16'h0195, 1, 0, 0, 0, 4'h0, 16'h0);

    i_stall = 1'b1;
    i_rst = 1'b1;
    #1;
    compare("async_rst", bubble());
    #2;
    i_rst = 1'b0;
    model_reset();
    step("post_rst", 16'h0134, 1, 0, 0, 0, 4'h0, 16'h0);
    step("post_rst_r9", 16'h0190, 1, 0, 0, 0, 4'h0, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
